// File: rtl/rr_combiner_pkg.sv
// rr_combiner_pkg
//   Shared types and default parameter values for the round-robin combiner
//   scheduler and its priority picker.
//   Contents:
//     state_t           output-register FSM state (EMPTY, FULL)
//     DEF_*             default parameter values used by the modules
package rr_combiner_pkg;

   localparam int DEF_NUM_CHANNELS      = 4;
   localparam int DEF_CHANNEL_WIDTH_IN  = 32;
   localparam int DEF_CHANNEL_WIDTH_OUT = 64;
   localparam int DEF_TAG_MSB           = 55;
   localparam int DEF_TAG_LSB           = 48;
   localparam int DEF_MAX_BURST         = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
//   Rotating-priority search: starting at rr_ptr and wrapping modulo
//   NUM_CHANNELS, the first channel with in_valid set wins.
//   Ports:
//     in_valid   [NUM_CHANNELS-1:0]          per-channel request
//     rr_ptr     [$clog2(NUM_CHANNELS)-1:0]  highest-priority channel
//     grant_oh   [NUM_CHANNELS-1:0]          one-hot winner (zero if none)
//     grant_idx  [$clog2(NUM_CHANNELS)-1:0]  winner index (zero if none)
//     any_valid                              at least one request present
module rr_priority_picker
   import rr_combiner_pkg::*;
#(
   parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
) (
   input  logic [NUM_CHANNELS-1:0]         in_valid,
   input  logic [$clog2(NUM_CHANNELS)-1:0] rr_ptr,
   output logic [NUM_CHANNELS-1:0]         grant_oh,
   output logic [$clog2(NUM_CHANNELS)-1:0] grant_idx,
   output logic                            any_valid
);

   localparam int IDX_W = $clog2(NUM_CHANNELS);
   localparam int CND_W = IDX_W + 1;
   localparam logic [CND_W-1:0] NUM_W = CND_W'(NUM_CHANNELS);

   // One extra bit holds rr_ptr + offset before the modulo fold.
   logic [CND_W-1:0] cand;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      cand      = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         cand = {1'b0, rr_ptr} + CND_W'(i);
         if (cand >= NUM_W) begin
            cand = cand - NUM_W;
         end
         if (!any_valid && in_valid[cand[IDX_W-1:0]]) begin
            any_valid                 = 1'b1;
            grant_idx                 = cand[IDX_W-1:0];
            grant_oh[cand[IDX_W-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_combiner_scheduler.sv
// rr_combiner_scheduler
//   Merges NUM_CHANNELS valid/ready input streams into one registered,
//   tagged output stream with round-robin arbitration.  The output word
//   carries the payload in its low bits and the source channel index in
//   [TAG_MSB:TAG_LSB]; all other bits are zero.
//   Build option: RR_COMBINER_BURST_LOCK_EN keeps the grant on one channel
//   for up to MAX_BURST consecutive beats while it stays valid.
//   Ports:
//     clk        sole clock, rising edge
//     reset      asynchronous active-low reset
//     in_data    packed payloads, channel i at [i*CHANNEL_WIDTH_IN +: CHANNEL_WIDTH_IN]
//     in_valid   per-channel valid
//     in_ready   per-channel ready, at most one bit high
//     out_data   registered tagged word
//     out_valid  registered output valid
//     out_ready  downstream ready
//     grant_idx  channel accepted this cycle (don't-care when none)
//
//   state | meaning
//   ------+-------------------------------------------
//   EMPTY | output register holds nothing, out_valid=0
//   FULL  | output register holds a beat,  out_valid=1
module rr_combiner_scheduler
   import rr_combiner_pkg::*;
#(
   parameter int NUM_CHANNELS      = DEF_NUM_CHANNELS,
   parameter int CHANNEL_WIDTH_IN  = DEF_CHANNEL_WIDTH_IN,
   parameter int CHANNEL_WIDTH_OUT = DEF_CHANNEL_WIDTH_OUT,
   parameter int TAG_MSB           = DEF_TAG_MSB,
   parameter int TAG_LSB           = DEF_TAG_LSB,
   parameter int MAX_BURST         = DEF_MAX_BURST
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [CHANNEL_WIDTH_IN*NUM_CHANNELS-1:0] in_data,
   input  logic [NUM_CHANNELS-1:0]                in_valid,
   output logic [NUM_CHANNELS-1:0]                in_ready,
   output logic [CHANNEL_WIDTH_OUT-1:0]           out_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [$clog2(NUM_CHANNELS)-1:0]        grant_idx
);

   localparam int IDX_W = $clog2(NUM_CHANNELS);
   localparam int TAG_W = TAG_MSB - TAG_LSB + 1;
   localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CHANNELS - 1);

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        rr_ptr, rr_ptr_d;
   logic [NUM_CHANNELS-1:0] pick_oh;
   logic [IDX_W-1:0]        pick_idx;
   logic                    any_valid;
   logic                    load_en;
   logic                    accept;
   logic [CHANNEL_WIDTH_IN-1:0]  payload;
   logic [CHANNEL_WIDTH_OUT-1:0] word_d;

   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      return (p == LAST_CH) ? '0 : p + 1'b1;
   endfunction

   rr_priority_picker #(
      .NUM_CHANNELS (NUM_CHANNELS)
   ) u_picker (
      .in_valid  (in_valid),
      .rr_ptr    (rr_ptr),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .any_valid (any_valid)
   );

   // Gating with reset keeps in_ready low while reset is held even though
   // the cleared register reads as empty.
   assign load_en   = (state_q == EMPTY) || out_ready;
   assign accept    = reset && load_en && any_valid;
   assign in_ready  = accept ? pick_oh : '0;
   assign grant_idx = pick_idx;
   assign out_valid = (state_q == FULL);

   always_comb begin
      payload = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (pick_oh[i]) begin
            payload = in_data[i*CHANNEL_WIDTH_IN +: CHANNEL_WIDTH_IN];
         end
      end
      word_d                          = '0;
      word_d[CHANNEL_WIDTH_IN-1:0]    = payload;
      word_d[TAG_MSB:TAG_LSB]         = TAG_W'(pick_idx);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (out_ready && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= EMPTY;
         out_data <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            out_data <= word_d;
         end
      end
   end

`ifdef RR_COMBINER_BURST_LOCK_EN
   localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

   // While locked, rr_ptr points at the locked channel and burst_cnt counts
   // the beats it has already been granted in this burst.
   logic [BURST_W-1:0] burst_cnt, burst_cnt_d;
   logic [BURST_W-1:0] prior_beats;
   logic               lock, lock_d;

   always_comb begin
      rr_ptr_d    = rr_ptr;
      burst_cnt_d = burst_cnt;
      lock_d      = lock;
      prior_beats = (lock && (pick_idx == rr_ptr)) ? burst_cnt : '0;
      if (accept) begin
         if (prior_beats == BURST_LAST) begin
            rr_ptr_d    = ptr_inc(pick_idx);
            burst_cnt_d = '0;
            lock_d      = 1'b0;
         end else begin
            rr_ptr_d    = pick_idx;
            burst_cnt_d = prior_beats + 1'b1;
            lock_d      = 1'b1;
         end
      end else if (lock && !in_valid[rr_ptr]) begin
         rr_ptr_d    = ptr_inc(rr_ptr);
         burst_cnt_d = '0;
         lock_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= '0;
         burst_cnt <= '0;
         lock      <= 1'b0;
      end else begin
         rr_ptr    <= rr_ptr_d;
         burst_cnt <= burst_cnt_d;
         lock      <= lock_d;
      end
   end
`else
   assign rr_ptr_d = accept ? ptr_inc(pick_idx) : rr_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else begin
         rr_ptr <= rr_ptr_d;
      end
   end
`endif

endmodule

// File: tb/tb_rr_combiner_scheduler.sv
// tb_rr_combiner_scheduler
//   Self-checking bench: a behavioural model (integer round-robin pointer,
//   one-entry output register, beat scoreboard) checked every cycle, plus
//   directed literal sequences.
module tb_rr_combiner_scheduler;

   localparam int N  = 4;
   localparam int WI = 32;
   localparam int MB = 4;

   logic            clk;
   logic            reset;
   logic [WI*N-1:0] in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [63:0]     out_data;
   logic            out_valid;
   logic            out_ready;
   logic [1:0]      grant_idx;

   int vectors = 0;
   int errors  = 0;

   rr_combiner_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant_idx (grant_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mk_word(input int ch, input logic [31:0] p);
      return (64'(ch) << 48) | 64'(p);
   endfunction

   // ---------------- behavioural model ----------------
   int          m_ptr;
   bit          m_vld;
   logic [63:0] m_data;
   bit          m_locked;
   int          m_lock_ch;
   int          m_beats;
   logic [63:0] sb[$];

   task automatic m_reset();
      m_ptr = 0; m_vld = 0; m_data = '0;
      m_locked = 0; m_lock_ch = 0; m_beats = 0;
      sb.delete();
   endtask

   initial m_reset();

   always @(negedge clk) begin
      int g;
      int n;
      bit load;
      logic [N-1:0] exp_rdy;
      logic [63:0] e;
      if (!reset) begin
         m_reset();
         chk("rst_in_ready", 64'(in_ready), 64'd0);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
      end else begin
         g = -1;
         for (int i = 0; i < N; i++) begin
            if (g < 0 && in_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
         end
         load    = !m_vld || out_ready;
         exp_rdy = (load && g >= 0) ? N'(1 << g) : '0;
         chk("in_ready", 64'(in_ready), 64'(exp_rdy));
         chk("onehot", 64'($countones(in_ready) <= 1), 64'd1);
         if (exp_rdy != 0) chk("grant_idx", 64'(grant_idx), 64'(g));
         chk("out_valid", 64'(out_valid), 64'(m_vld));
         if (m_vld) chk("out_data", out_data, m_data);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_data", out_data, e);
            end
         end
         // advance to the state after the coming rising edge
         if (exp_rdy != 0) begin
            m_data = mk_word(g, in_data[g*WI +: WI]);
            m_vld  = 1;
            sb.push_back(m_data);
`ifdef RR_COMBINER_BURST_LOCK_EN
            n = (m_locked && g == m_lock_ch) ? m_beats + 1 : 1;
            if (n >= MB) begin
               m_ptr = (g + 1) % N; m_locked = 0; m_beats = 0;
            end else begin
               m_ptr = g; m_locked = 1; m_lock_ch = g; m_beats = n;
            end
`else
            n = 0;
            m_ptr = (g + 1) % N;
`endif
         end else begin
            if (m_vld && out_ready) m_vld = 0;
`ifdef RR_COMBINER_BURST_LOCK_EN
            if (m_locked && !in_valid[m_lock_ch]) begin
               m_ptr = (m_lock_ch + 1) % N; m_locked = 0; m_beats = 0;
            end
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic [N-1:0] v, input logic r,
                       input logic [31:0] d2, input bit fix2);
      @(posedge clk);
      #1;
      in_valid  = v;
      out_ready = r;
      for (int i = 0; i < N; i++) in_data[i*WI +: WI] = $urandom;
      if (fix2) in_data[2*WI +: WI] = d2;
      @(negedge clk);
   endtask

   logic [7:0] tags[$];
   logic [7:0] exp_tags[8];

   initial begin
      reset     = 1'b0;
      in_valid  = 4'hF;
      out_ready = 1'b0;
      in_data   = '0;
      #7;
      chk("reset_in_ready", 64'(in_ready), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_data", out_data, 64'd0);
      @(posedge clk);
      #1;
      in_valid = '0;
      reset    = 1'b1;

      // tag sequence, one beat per cycle
`ifdef RR_COMBINER_BURST_LOCK_EN
      exp_tags = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
      for (int c = 0; c < 10; c++) begin
         step(4'b0011, 1'b1, 32'd0, 1'b0);
`else
      exp_tags = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
      for (int c = 0; c < 10; c++) begin
         step(4'b1111, 1'b1, 32'd0, 1'b0);
`endif
         if (c == 0) begin
            chk("first_in_ready", 64'(in_ready), 64'd1);
            chk("first_out_valid0", 64'(out_valid), 64'd0);
         end
         if (c == 1) chk("first_out_valid1", 64'(out_valid), 64'd1);
         if (out_valid && out_ready) tags.push_back(out_data[55:48]);
      end
      for (int j = 0; j < 8; j++) chk($sformatf("tag_seq%0d", j), 64'(tags[j]), 64'(exp_tags[j]));

      // hold under back-pressure
      step(4'b0000, 1'b1, 32'd0, 1'b0);
      step(4'b0000, 1'b1, 32'd0, 1'b0);
      step(4'b0100, 1'b0, 32'hDEAD_BEEF, 1'b1);
      chk("hold_accept", 64'(in_ready), 64'h4);
      for (int c = 0; c < 5; c++) begin
         step(4'b0100, 1'b0, 32'h1111_1111, 1'b1);
         chk("hold_data", out_data, 64'h0002_0000_DEAD_BEEF);
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_ready", 64'(in_ready), 64'd0);
      end
      step(4'b0100, 1'b1, 32'h2222_2222, 1'b1);
      chk("drain_data", out_data, 64'h0002_0000_DEAD_BEEF);
      chk("drain_reload", 64'(in_ready), 64'h4);

      // wrap-around grant
      step(4'b0010, 1'b1, 32'd0, 1'b0);
      chk("wrap_ready", 64'(in_ready), 64'h2);
      chk("wrap_idx", 64'(grant_idx), 64'd1);
      step(4'b1111, 1'b1, 32'd0, 1'b0);
`ifndef RR_COMBINER_BURST_LOCK_EN
      chk("wrap_next_ready", 64'(in_ready), 64'h4);
`endif
      @(posedge clk);
      #1;
`ifndef RR_COMBINER_BURST_LOCK_EN
      chk("model_ptr", 64'(m_ptr), 64'd3);
`endif

      // async reset with a held beat
      in_valid  = '0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("pre_reset_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("async_out_valid", 64'(out_valid), 64'd0);
      chk("async_out_data", out_data, 64'd0);
      in_valid = 4'hF;
      #1;
      chk("async_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      in_valid = '0;
      reset    = 1'b1;
      step(4'b1010, 1'b1, 32'd0, 1'b0);
      chk("post_reset_grant", 64'(in_ready), 64'h2);

      // random traffic
      for (int c = 0; c < 10000; c++) begin
         step(4'($urandom_range(0, 15)),
              (c < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0),
              32'd0, 1'b0);
      end
      step(4'b0000, 1'b1, 32'd0, 1'b0);
      step(4'b0000, 1'b1, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/rr_combiner_scheduler.md
RR_COMBINER_SCHEDULER -- requirements
Module: rr_combiner_scheduler

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of input channels (>=2).
REQ-002 SHALL have parameter CHANNEL_WIDTH_IN, default 32, input payload width.
REQ-003 SHALL have parameter CHANNEL_WIDTH_OUT, default 64, output word width.
REQ-004 SHALL have parameter TAG_MSB, default 55, and TAG_LSB, default 48, which locate the source-index tag field in out_data.
REQ-005 SHALL have parameter MAX_BURST, default 4, maximum consecutive beats granted to one channel (>=1).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port in_data  input  CHANNEL_WIDTH_IN*NUM_CHANNELS  packed payloads, channel i at bits [i*CHANNEL_WIDTH_IN +: CHANNEL_WIDTH_IN].
REQ-009 SHALL have port in_valid  input  NUM_CHANNELS  per-channel valid.
REQ-010 SHALL have port in_ready  output  NUM_CHANNELS  per-channel ready, at most one bit high.
REQ-011 SHALL have port out_data  output  CHANNEL_WIDTH_OUT  registered tagged word.
REQ-012 SHALL have port out_valid  output  1  registered output valid.
REQ-013 SHALL have port out_ready  input  1  downstream ready.
REQ-014 SHALL have port grant_idx  output  $clog2(NUM_CHANNELS)  index of the channel accepted in the current cycle (don't-care when no accept).

Function
REQ-015 SHALL transfer an input beat on channel i only in a cycle where in_valid[i] && in_ready[i]; SHALL transfer an output beat only when out_valid && out_ready.
REQ-016 SHALL hold a one-entry output register; load_en = !out_valid || out_ready.
REQ-017 SHALL drive in_ready[g] = load_en && in_valid[g] for the granted channel g only, with every other bit 0 (combinational from in_valid, out_valid, out_ready and state).
REQ-018 SHALL select g round-robin: search starts at rr_ptr, wrapping modulo NUM_CHANNELS; first channel with in_valid set wins.
REQ-019 SHALL, after an accepted beat from channel k with no burst lock active, set rr_ptr = (k+1) mod NUM_CHANNELS; rr_ptr SHALL be unchanged when no beat is accepted.
REQ-020 SHALL load out_data on accept with bits [CHANNEL_WIDTH_IN-1:0] = payload, bits [TAG_MSB:TAG_LSB] = zero-extended k, and all other bits zero; latency is one cycle from input accept to out_valid.
REQ-021 SHALL keep out_data and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL sustain one beat per cycle when out_ready is held high, including a simultaneous drain and load in the same cycle.
REQ-023 SHALL clear out_valid after a drain with no simultaneous accept.
REQ-024 SHALL implement a two-state FSM: EMPTY (out_valid=0) -> FULL on accept; FULL -> EMPTY on drain without accept; FULL -> FULL on drain with accept or on stall.

Reset
REQ-025 SHALL, while reset is low, asynchronously force out_valid=0, out_data=0, rr_ptr=0, burst_cnt=0, lock=0, FSM=EMPTY; in_ready SHALL read all-zero during reset.
REQ-026 SHALL discard any held beat when reset is asserted mid-operation; the first post-reset grant SHALL start the search from channel 0.

Configuration
REQ-027 SHALL honour macro RR_COMBINER_BURST_LOCK_EN: when defined, after an accept from k the grant SHALL stay on k (rr_ptr held, burst_cnt incremented) while in_valid[k] stays high and burst_cnt < MAX_BURST-1; reaching MAX_BURST beats, or k deasserting valid, SHALL clear burst_cnt and advance rr_ptr to k+1.
REQ-028 SHALL, when RR_COMBINER_BURST_LOCK_EN is undefined, omit burst_cnt and lock logic and re-arbitrate every beat per REQ-019.

Structure
REQ-029 SHALL place the FSM state enum (EMPTY, FULL) and the default-parameter constants in package rr_combiner_pkg.
REQ-030 SHALL instantiate sub-module rr_priority_picker (in_valid, rr_ptr -> one-hot grant, grant index, any_valid) for the rotating priority search.

Verification
REQ-031 SHALL verify: all 4 channels valid, out_ready=1 constantly, lock disabled -> tags 0,1,2,3,0,... one per cycle, first out_valid one cycle after the first accept.
REQ-032 SHALL verify: channel 2 sends 0xDEADBEEF with out_ready=0 for 5 cycles -> out_data=0x0002_0000_DEAD_BEEF held stable and in_ready=0 until out_ready rises.
REQ-033 SHALL verify: lock enabled, MAX_BURST=4, channels 0 and 1 continuously valid -> tag sequence 0,0,0,0,1,1,1,1,0,...
REQ-034 SHALL verify: rr_ptr=3 and only channel 1 valid -> grant 1 (wrap-around), after which rr_ptr=2.
REQ-035 SHALL verify: reset asserted while out_valid=1 with a beat held -> out_valid=0 immediately (asynchronously), and the first grant after release goes to the lowest valid channel.
REQ-036 SHALL verify: random valid and out_ready for 10k cycles -> in_ready stays one-hot-or-zero, no beat is lost or duplicated, and tags match the scoreboard.
